// File: rtl/led_strip_pkg.sv
// led_strip_pkg: shared op-codes, mode/state enums and base palette for the LED strip engine
package led_strip_pkg;
   localparam logic [3:0] OP_NOP       = 4'd0;
   localparam logic [3:0] OP_PWR       = 4'd1;
   localparam logic [3:0] OP_MODE_UP   = 4'd2;
   localparam logic [3:0] OP_MODE_DN   = 4'd3;
   localparam logic [3:0] OP_COLOR_UP  = 4'd4;
   localparam logic [3:0] OP_COLOR_DN  = 4'd5;
   localparam logic [3:0] OP_BRIGHT_UP = 4'd6;
   localparam logic [3:0] OP_BRIGHT_DN = 4'd7;
   // op-codes with this bit set select colour cmd_op[2:0] directly
   localparam int OP_COLOR_SEL = 3;
   typedef enum logic [1:0] {SOLID, BLINK, RAINBOW, CHASE} mode_e;
   typedef enum logic [1:0] {ST_OFF, ST_LOAD, ST_RUN} state_e;
   // element k is palette entry k (element 0 in the least significant slot)
   localparam logic [7:0][23:0] BASE_PALETTE = {
      24'hFFFFFF, 24'h6400FF, 24'hFF00FF, 24'hFF6400,
      24'hFFFF00, 24'h0000FF, 24'h00FF00, 24'hFF0000
   };
endpackage

// File: rtl/led_palette_rom.sv
// led_palette_rom: combinational palette lookup, index -> {R,G,B} scaled to CHAN_W
//   idx  in   COLOR_W     palette index (entry uses idx mod 8)
//   rgb  out  3*CHAN_W    colour, R in the most significant channel
module led_palette_rom
   import led_strip_pkg::*;
#(
   parameter int CHAN_W  = 8,
   parameter int COLOR_W = 3
)(
   input  logic [COLOR_W-1:0]  idx,
   output logic [3*CHAN_W-1:0] rgb
);
   logic [23:0] base;
   assign base = BASE_PALETTE[3'(idx)];
   // keep the top CHAN_W bits of each 8-bit channel (zero-padded when CHAN_W > 8)
   for (genvar c = 0; c < 3; c++) begin : g_ch
      assign rgb[c*CHAN_W +: CHAN_W] = CHAN_W'({base[c*8 +: 8], CHAN_W'(0)} >> 8);
   end
endmodule

// File: rtl/led_strip_engine.sv
// led_strip_engine: command-driven animated LED strip renderer with brightness scaling
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_op      4-bit command, taken when cmd_valid && cmd_ready
//   cmd_ready             low only while the rainbow buffer is reloading
//   strip                 registered pixels, pixel i at [(i+1)*3*CHAN_W-1 : i*3*CHAN_W]
//   frame_valid           one-cycle pulse when strip changes
//   power_on, mode, color_code, brightness   current engine state
module led_strip_engine
   import led_strip_pkg::*;
#(
   parameter int NUM_PIXELS    = 10,
   parameter int CHAN_W        = 8,
   parameter int BRIGHT_W      = 3,
   parameter int PALETTE_DEPTH = 8,
   parameter int TICK_DIV      = 1
)(
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                cmd_valid,
   input  logic [3:0]                          cmd_op,
   output logic                                cmd_ready,
   output logic [NUM_PIXELS*3*CHAN_W-1:0]      strip,
   output logic                                frame_valid,
   output logic                                power_on,
   output logic [1:0]                          mode,
   output logic [$clog2(PALETTE_DEPTH)-1:0]    color_code,
   output logic [BRIGHT_W-1:0]                 brightness
);
   localparam int COLOR_W = $clog2(PALETTE_DEPTH);
   localparam int PIX_W   = $clog2(NUM_PIXELS);
   localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int PX_W    = 3 * CHAN_W;
   localparam int PROD_W  = CHAN_W + BRIGHT_W + 1;
   localparam logic [BRIGHT_W-1:0] MAX_B = '1;

   state_e                     state, state_n;
   mode_e                      mode_q, mode_n;
   logic [COLOR_W-1:0]         color_q, color_n;
   logic [BRIGHT_W-1:0]        bright_q, bright_n;
   logic [PIX_W-1:0]           load_idx, chase;
   logic [TICK_W-1:0]          tick_cnt;
   logic                       phase, accept, tick, run;
   logic [PX_W-1:0]            solid_rgb, load_rgb;
   logic [PX_W-1:0]            rbuf [NUM_PIXELS];
   logic [NUM_PIXELS*PX_W-1:0] strip_n;

   assign accept     = cmd_valid && cmd_ready;
   assign tick       = (tick_cnt == TICK_W'(TICK_DIV - 1));
   // animate and render only on cycles that stay in RUN; a reload drops the tick
   assign run        = (state == ST_RUN) && (state_n == ST_RUN);
   assign power_on   = (state != ST_OFF);
   assign mode       = mode_q;
   assign color_code = color_q;
   assign brightness = bright_q;

   led_palette_rom #(.CHAN_W(CHAN_W), .COLOR_W(COLOR_W)) u_solid (
      .idx (color_q),
      .rgb (solid_rgb)
   );

   led_palette_rom #(.CHAN_W(CHAN_W), .COLOR_W(COLOR_W)) u_load (
      .idx (color_q + COLOR_W'(load_idx)),
      .rgb (load_rgb)
   );

   always_comb begin
      state_n   = state;
      mode_n    = mode_q;
      color_n   = color_q;
      bright_n  = bright_q;
      cmd_ready = (state != ST_LOAD);
      if (accept && cmd_op == OP_PWR) begin
         state_n  = ST_LOAD;
         mode_n   = SOLID;
         color_n  = '0;
         bright_n = MAX_B;
      end else if (state == ST_LOAD) begin
         state_n = (load_idx == PIX_W'(NUM_PIXELS - 1)) ? ST_RUN : ST_LOAD;
      end else if (accept && state == ST_RUN) begin
         case (cmd_op)
            OP_MODE_UP:   mode_n   = mode_e'(mode_q + 2'd1);
            OP_MODE_DN:   mode_n   = mode_e'(mode_q - 2'd1);
            OP_COLOR_UP:  color_n  = color_q + COLOR_W'(1);
            OP_COLOR_DN:  color_n  = color_q - COLOR_W'(1);
            OP_BRIGHT_UP: bright_n = (bright_q == MAX_B) ? bright_q : bright_q + BRIGHT_W'(1);
            OP_BRIGHT_DN: bright_n = (bright_q == '0) ? bright_q : bright_q - BRIGHT_W'(1);
            default:      color_n  = (cmd_op[OP_COLOR_SEL] && 32'(cmd_op[2:0]) < PALETTE_DEPTH) ?
                                     COLOR_W'(cmd_op[2:0]) : color_q;
         endcase
         state_n = (color_n != color_q) ? ST_LOAD : ST_RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_OFF;
         mode_q   <= SOLID;
         color_q  <= '0;
         bright_q <= MAX_B;
      end else begin
         state    <= state_n;
         mode_q   <= mode_n;
         color_q  <= color_n;
         bright_q <= bright_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_idx <= '0;
         tick_cnt <= '0;
         phase    <= 1'b0;
         chase    <= '0;
      end else begin
         load_idx <= (state == ST_LOAD && state_n == ST_LOAD) ? load_idx + PIX_W'(1) : '0;
         tick_cnt <= (!run || tick) ? '0 : tick_cnt + TICK_W'(1);
         phase    <= run && (phase ^ tick);
         chase    <= !run ? '0 : !tick ? chase :
                     (chase == PIX_W'(NUM_PIXELS - 1)) ? '0 : chase + PIX_W'(1);
      end
   end

   // rainbow buffer contents are don't-care until a reload, so it carries no reset
   always_ff @(posedge clk) begin
      if (state == ST_LOAD)
         rbuf[load_idx] <= load_rgb;
      else if (run && tick)
         for (int i = 0; i < NUM_PIXELS; i++) rbuf[i] <= rbuf[(i + NUM_PIXELS - 1) % NUM_PIXELS];
   end

   for (genvar p = 0; p < NUM_PIXELS; p++) begin : g_px
      logic [PX_W-1:0] raw;
      assign raw = (mode_q == SOLID)   ? solid_rgb :
                   (mode_q == BLINK)   ? (phase ? solid_rgb : '0) :
                   (mode_q == RAINBOW) ? rbuf[p] :
                   ((chase == PIX_W'(p)) ? solid_rgb : '0);
      for (genvar c = 0; c < 3; c++) begin : g_ch
         logic [PROD_W-1:0] prod;
         assign prod = PROD_W'(raw[c*CHAN_W +: CHAN_W]) * (PROD_W'(bright_q) + PROD_W'(1));
         assign strip_n[p*PX_W + c*CHAN_W +: CHAN_W] = CHAN_W'(prod >> BRIGHT_W);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strip       <= '0;
         frame_valid <= 1'b0;
      end else begin
         frame_valid <= run && (strip_n != strip);
         if (state == ST_OFF)
            strip <= '0;
         else if (run)
            strip <= strip_n;
      end
   end
endmodule

// File: tb/tb_led_strip_engine.sv
// tb_led_strip_engine: randomized + directed check of led_strip_engine against a behavioural model
module tb_led_strip_engine;
   localparam int NP   = 10;
   localparam int SW   = NP * 24;
   localparam int TDIV = 3;
   localparam logic [23:0] PAL [8] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
                                       24'hFF6400, 24'hFF00FF, 24'h6400FF, 24'hFFFFFF};

   logic          clk = 1'b0, rst_n = 1'b1, cmd_valid = 1'b0;
   logic [3:0]    cmd_op = 4'd0;
   logic          cmd_ready, frame_valid, power_on;
   logic [SW-1:0] strip;
   logic [1:0]    mode;
   logic [2:0]    color_code, brightness;

   int checks = 0, failures = 0, lows = 0, fv_seen = 0;
   int m_on, m_load, m_mode, m_col, m_br, m_tcnt, m_phase, m_chase;
   int m_rbuf [NP];
   logic [SW-1:0] m_strip, e;
   logic          m_fv;
   int prev, lit, run_len, bad, wrap, changes;
   logic [23:0] rb [NP] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00, 24'hFF6400,
                            24'hFF00FF, 24'h6400FF, 24'hFFFFFF, 24'hFF0000, 24'h00FF00};

   led_strip_engine #(.NUM_PIXELS(NP), .CHAN_W(8), .BRIGHT_W(3), .PALETTE_DEPTH(8), .TICK_DIV(TDIV)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_op      (cmd_op),
      .cmd_ready   (cmd_ready),
      .strip       (strip),
      .frame_valid (frame_valid),
      .power_on    (power_on),
      .mode        (mode),
      .color_code  (color_code),
      .brightness  (brightness)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] scale(input logic [23:0] c, input int b);
      logic [23:0] r;
      for (int k = 0; k < 3; k++) r[k*8 +: 8] = 8'((int'(c[k*8 +: 8]) * (b + 1)) / 8);
      return r;
   endfunction

   function automatic logic [SW-1:0] render();
      logic [SW-1:0] s;
      logic [23:0]   c;
      s = '0;
      for (int i = 0; i < NP; i++) begin
         case (m_mode)
            0:       c = PAL[m_col];
            1:       c = (m_phase != 0) ? PAL[m_col] : 24'h0;
            2:       c = PAL[m_rbuf[i]];
            default: c = (i == m_chase) ? PAL[m_col] : 24'h0;
         endcase
         s[i*24 +: 24] = scale(c, m_br);
      end
      return s;
   endfunction

   task automatic model_reset();
      m_on = 0; m_load = 0; m_mode = 0; m_col = 0; m_br = 7;
      m_tcnt = 0; m_phase = 0; m_chase = 0; m_strip = '0; m_fv = 1'b0;
   endtask

   task automatic model_edge(input logic v, input logic [3:0] op);
      logic acc, run, enter;
      logic [SW-1:0] f;
      int old_col, t;
      acc = v && (m_load == 0);
      run = (m_on != 0) && (m_load == 0);
      enter = 1'b0;
      f = render();
      old_col = m_col;
      if (acc && op == 4'd1) begin
         m_on = 1; m_mode = 0; m_col = 0; m_br = 7; enter = 1'b1;
      end else if (acc && run) begin
         if (op >= 8) m_col = int'(op) - 8;
         else if (op == 2) m_mode = (m_mode + 1) % 4;
         else if (op == 3) m_mode = (m_mode + 3) % 4;
         else if (op == 4) m_col = (m_col + 1) % 8;
         else if (op == 5) m_col = (m_col + 7) % 8;
         else if (op == 6) m_br = (m_br < 7) ? m_br + 1 : 7;
         else if (op == 7) m_br = (m_br > 0) ? m_br - 1 : 0;
         enter = (m_col != old_col);
      end
      m_fv = 1'b0;
      if (run && !enter) begin
         m_fv = (f != m_strip);
         m_strip = f;
         if (m_tcnt == TDIV - 1) begin
            m_tcnt = 0;
            m_phase ^= 1;
            m_chase = (m_chase + 1) % NP;
            t = m_rbuf[NP-1];
            for (int i = NP - 1; i > 0; i--) m_rbuf[i] = m_rbuf[i-1];
            m_rbuf[0] = t;
         end else m_tcnt++;
      end
      if (enter) begin
         m_load = NP; m_tcnt = 0; m_phase = 0; m_chase = 0;
         for (int i = 0; i < NP; i++) m_rbuf[i] = (m_col + i) % 8;
      end else if (m_load > 0) m_load--;
   endtask

   task automatic compare_all();
      check("cmd_ready", SW'(cmd_ready), SW'(m_load == 0));
      check("power_on", SW'(power_on), SW'(m_on != 0));
      check("mode", SW'(mode), SW'(m_mode));
      check("color_code", SW'(color_code), SW'(m_col));
      check("brightness", SW'(brightness), SW'(m_br));
      check("frame_valid", SW'(frame_valid), SW'(m_fv));
      check("strip", strip, m_strip);
   endtask

   task automatic cycle(input logic v, input logic [3:0] op);
      cmd_valid = v;
      cmd_op = op;
      @(posedge clk);
      model_edge(v, op);
      #1;
      compare_all();
      if (!cmd_ready) lows++;
      if (frame_valid) fv_seen = 1;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      compare_all();
      rst_n = 1'b1;
      lows = 0; fv_seen = 0;
      cycle(1'b1, 4'd1);
      repeat (13) cycle(1'b0, 4'd0);
      check("pwr_load_len", SW'(lows), SW'(10));
      check("pwr_fv", SW'(fv_seen), SW'(1));
      check("pwr_red", strip, {NP{24'hFF0000}});
      cycle(1'b1, 4'd4);
      repeat (12) cycle(1'b0, 4'd0);
      repeat (4) cycle(1'b1, 4'd7);
      repeat (2) cycle(1'b0, 4'd0);
      check("bright3_green", strip, {NP{24'h007F00}});
      repeat (5) cycle(1'b1, 4'd7);
      repeat (2) cycle(1'b0, 4'd0);
      check("bright0_green", strip, {NP{24'h001F00}});
      repeat (7) cycle(1'b1, 4'd6);
      repeat (2) cycle(1'b1, 4'd2);
      cycle(1'b1, 4'd8);
      repeat (11) cycle(1'b0, 4'd0);
      for (int i = 0; i < NP; i++) e[i*24 +: 24] = rb[i];
      check("rainbow", strip, e);
      repeat (3) cycle(1'b0, 4'd0);
      check("rainbow_px0", SW'(strip[23:0]), SW'(24'h00FF00));
      check("rainbow_px1", SW'(strip[47:24]), SW'(24'hFF0000));
      lows = 0;
      cycle(1'b1, 4'd12);
      repeat (12) cycle(1'b0, 4'd0);
      check("sel4_load_len", SW'(lows), SW'(10));
      check("sel4_color", SW'(color_code), SW'(4));
      lows = 0;
      cycle(1'b1, 4'd12);
      repeat (3) cycle(1'b0, 4'd0);
      check("sel4_again_noload", SW'(lows), SW'(0));
      cycle(1'b1, 4'd8);
      repeat (12) cycle(1'b0, 4'd0);
      cycle(1'b1, 4'd5);
      check("color_dn_wrap", SW'(color_code), SW'(7));
      repeat (12) cycle(1'b0, 4'd0);
      cycle(1'b1, 4'd1);
      repeat (12) cycle(1'b0, 4'd0);
      cycle(1'b1, 4'd3);
      check("mode_dn_wrap", SW'(mode), SW'(3));
      prev = -1; run_len = 0; bad = 0; wrap = 0; changes = 0;
      repeat (40) begin
         cycle(1'b0, 4'd0);
         lit = -1;
         for (int i = 0; i < NP; i++) if (strip[i*24 +: 24] != 24'h0) lit = i;
         run_len++;
         if (lit != prev) begin
            changes++;
            if (changes >= 3 && run_len != TDIV) bad++;
            if (changes >= 3 && prev == NP - 1 && lit == 0) wrap = 1;
            prev = lit;
            run_len = 0;
         end
      end
      check("chase_step", SW'(bad), SW'(0));
      check("chase_wrap", SW'(wrap), SW'(1));
      cycle(1'b1, 4'd4);
      repeat (3) cycle(1'b0, 4'd0);
      do_reset();
      check("rst_strip", strip, '0);
      cycle(1'b1, 4'd4);
      repeat (2) cycle(1'b0, 4'd0);
      check("off_color", SW'(color_code), SW'(0));
      check("off_power", SW'(power_on), SW'(0));
      cycle(1'b1, 4'd1);
      for (int n = 0; n < 2500; n++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         else cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
